param_accumulator: RTL and testbench
====================================

PARAM_ACCUMULATOR -- requirements
Module: param_accumulator

Interface
REQ-001 SHALL provide parameter IN_W, default 16, signed input operand width.
REQ-002 SHALL provide parameter ACC_W, default 32, signed accumulator width; legal only when ACC_W >= IN_W+1.
REQ-003 SHALL provide parameter NUM_CH, default 4, number of independent accumulator channels (>= 2).
REQ-004 SHALL provide parameter SAT_EN, default 1; 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-005 SHALL derive localparam CH_W = clog2(NUM_CH).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  request accepted on this edge when in_valid & in_ready.
REQ-010 in_ch  input  CH_W  target channel.
REQ-011 in_op  input  2  00 read, 01 add, 10 subtract, 11 clear channel.
REQ-012 in_data  input  IN_W  signed operand; ignored for ops 00 and 11.
REQ-013 out_valid  output  1  result held in output register.
REQ-014 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-015 out_ch  output  CH_W  channel of the result.
REQ-016 out_acc  output  ACC_W  signed channel value after the operation.
REQ-017 out_ovf  output  1  sticky overflow flag of that channel after the operation.

Function
REQ-018 SHALL keep NUM_CH signed ACC_W accumulators and NUM_CH sticky overflow bits in registers.
REQ-019 in_ready SHALL equal (!out_valid | out_ready), combinationally; no other stall source.
REQ-020 On an accepted request at edge T, the channel register SHALL update at T; out_valid/out_ch/out_acc/out_ovf SHALL present the new value from T until consumed (latency 1 cycle).
REQ-021 Add: sign-extend in_data and acc to ACC_W+1 bits, compute acc + in_data; subtract: acc - in_data, same width.
REQ-022 Overflow SHALL be detected when the ACC_W+1-bit result lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-023 On overflow with SAT_EN=1 the result SHALL clamp to the nearest bound; with SAT_EN=0 it SHALL be the low ACC_W bits.
REQ-024 On overflow the channel's sticky bit SHALL set and remain set until op 11 on that channel or rst.
REQ-025 Op 11 SHALL zero the channel accumulator and its sticky bit; the output reports acc=0, ovf=0.
REQ-026 Op 00 SHALL leave state unchanged and report current acc and sticky bit.
REQ-027 Back-to-back accepted requests to the same channel SHALL each see the previous update (no stale reads, full throughput of one request per cycle when out_ready=1).
REQ-028 When out_valid & out_ready with no new accepted request, out_valid SHALL drop on that edge; output fields MAY hold their last value.
REQ-029 While out_valid=1 and out_ready=0, all output fields SHALL remain stable.
REQ-030 in_ch >= NUM_CH SHALL be accepted and dropped: no state change, no output produced.

Reset
REQ-031 On rst=1 at a clock edge: all accumulators=0, all sticky bits=0, out_valid=0, out_ch=0, out_acc=0, out_ovf=0; rst overrides a simultaneous request.
REQ-032 in_ready SHALL read 1 during and after reset (out_valid=0).

Verification
REQ-033 Defaults, out_ready=1: add 5 ch0, sub 3 ch0 on consecutive cycles -> out_acc 5 then 2, out_ovf 0, out_ch 0.
REQ-034 Subtract -32768 on fresh ch1 -> out_acc +32768, out_ovf 0; ch0 unaffected (read ch0 returns 2).
REQ-035 IN_W=16, ACC_W=17, SAT_EN=1: add 32767 to ch2 three times -> 32767, 65534, 65535 with out_ovf 0,0,1; read ch2 -> 65535, ovf 1; clear ch2 -> 0, ovf 0. Same with SAT_EN=0 -> third result -32771, ovf 1.
REQ-036 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, channel unchanged; raise out_ready -> queued request accepted next edge.
REQ-037 Add 1 to ch3 on four consecutive cycles -> out_acc 1,2,3,4 on consecutive cycles.
REQ-038 Assert rst for one cycle mid-sequence with in_valid=1 -> all outputs 0 next cycle; read each channel -> 0, ovf 0.

Source files
------------

// File: rtl/param_accumulator_if.sv
// Request/response bus of the multi-channel accumulator.
// The slave side is the accumulator; the master side issues requests and drains results.
interface param_accumulator_if #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic [1:0]              in_op;
  logic signed [IN_W-1:0]  in_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;

  modport master (
    output in_valid, in_ch, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_ch, in_op, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_acc, out_ovf
  );
endinterface

// File: rtl/param_accumulator.sv
// NUM_CH independent signed accumulators with sticky overflow flags and a single
// registered result slot; one request per cycle, read-modify-write in the same cycle.
module param_accumulator #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int NUM_CH = 4,
  parameter int SAT_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  param_accumulator_if.slave    bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  generate
    if (ACC_W < IN_W + 1) begin : g_bad_acc_w
      $error("param_accumulator: ACC_W must be at least IN_W+1");
    end
    if (NUM_CH < 2) begin : g_bad_num_ch
      $error("param_accumulator: NUM_CH must be at least 2");
    end
  endgenerate

  // The one guard bit disagrees with the accumulator sign bit exactly when the
  // extended result does not fit in ACC_W bits.
  function automatic logic is_ovf(input logic signed [EXT_W-1:0] v);
    return v[EXT_W-1] ^ v[EXT_W-2];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_wrap(input logic signed [EXT_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = v[ACC_W-1:0];
    if ((SAT_EN != 0) && is_ovf(v)) begin
      r = v[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0]       ovf_q, ovf_d;

  logic                    out_valid_q, out_valid_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                    accept;
  logic                    ch_ok;
  op_e                     op;
  logic signed [ACC_W-1:0] cur_acc;
  logic                    cur_ovf;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] opnd_ext;
  logic signed [EXT_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] res_acc;
  logic                    res_ovf;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;

  // Channel codes past NUM_CH only exist when NUM_CH is not a power of two.
  generate
    if ((1 << CH_W) == NUM_CH) begin : g_pow2
      assign ch_ok = 1'b1;
    end else begin : g_npow2
      assign ch_ok = ({1'b0, bus.in_ch} < (CH_W+1)'(NUM_CH));
    end
  endgenerate

  always_comb begin
    op       = op_e'(bus.in_op);
    cur_acc  = ch_ok ? acc_q[bus.in_ch] : '0;
    cur_ovf  = ch_ok ? ovf_q[bus.in_ch] : 1'b0;
    acc_ext  = {cur_acc[ACC_W-1], cur_acc};
    opnd_ext = {{(EXT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    sum_ext  = (op == OP_SUB) ? (acc_ext - opnd_ext) : (acc_ext + opnd_ext);

    res_acc = cur_acc;
    res_ovf = cur_ovf;
    case (op)
      OP_ADD, OP_SUB: begin
        res_acc = sat_wrap(sum_ext);
        res_ovf = cur_ovf | is_ovf(sum_ext);
      end
      OP_CLR: begin
        res_acc = '0;
        res_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_ch_d    = out_ch_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;

    // Dropped channels are still accepted so they never stall the requester.
    if (accept && ch_ok) begin
      acc_d[bus.in_ch] = res_acc;
      ovf_d[bus.in_ch] = res_ovf;
      out_valid_d      = 1'b1;
      out_ch_d         = bus.in_ch;
      out_acc_d        = res_acc;
      out_ovf_d        = res_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_param_accumulator.sv
// Bench for param_accumulator: three configurations share one stimulus stream,
// checked against directed expectations and an arithmetic reference model.
module tb_param_accumulator;
  localparam int NK = 3;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [1:0]         in_ch;
  logic [1:0]         in_op;
  logic signed [15:0] in_data;
  logic               out_ready;

  int n_tests;
  int n_fail;

  // Config 0: defaults. Config 1: 17-bit saturating. Config 2: 17-bit wrapping, 3 channels.
  param_accumulator_if #(.IN_W(16), .ACC_W(32), .NUM_CH(4)) if0 ();
  param_accumulator_if #(.IN_W(16), .ACC_W(17), .NUM_CH(4)) if1 ();
  param_accumulator_if #(.IN_W(16), .ACC_W(17), .NUM_CH(3)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_ch    = in_ch;     assign if1.in_ch    = in_ch;     assign if2.in_ch    = in_ch;
  assign if0.in_op    = in_op;     assign if1.in_op    = in_op;     assign if2.in_op    = in_op;
  assign if0.in_data  = in_data;   assign if1.in_data  = in_data;   assign if2.in_data  = in_data;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  param_accumulator #(.IN_W(16), .ACC_W(32), .NUM_CH(4), .SAT_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  param_accumulator #(.IN_W(16), .ACC_W(17), .NUM_CH(4), .SAT_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  param_accumulator #(.IN_W(16), .ACC_W(17), .NUM_CH(3), .SAT_EN(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_accw(int k);
    return (k == 0) ? 32 : 17;
  endfunction
  function automatic bit cfg_sat(int k);
    return (k != 2);
  endfunction
  function automatic int cfg_nch(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  // Reference model state: channel values as plain integers plus the visible result slot.
  longint m_acc [NK][4];
  bit     m_ovf [NK][4];
  bit     m_v   [NK];
  int     m_ch  [NK];
  longint m_out [NK];
  bit     m_o   [NK];
  bit     rdy_seen [NK];
  bit     started;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic get_dut(input int k, output bit v, output int ch, output longint acc,
                         output bit ovf, output bit rdy);
    case (k)
      0: begin v = if0.out_valid; ch = int'(if0.out_ch); acc = longint'($signed(if0.out_acc));
               ovf = if0.out_ovf; rdy = if0.in_ready; end
      1: begin v = if1.out_valid; ch = int'(if1.out_ch); acc = longint'($signed(if1.out_acc));
               ovf = if1.out_ovf; rdy = if1.in_ready; end
      default: begin v = if2.out_valid; ch = int'(if2.out_ch); acc = longint'($signed(if2.out_acc));
               ovf = if2.out_ovf; rdy = if2.in_ready; end
    endcase
  endtask

  // Fit an exact result into a w-bit signed range by clamping or modular wrap.
  task automatic fit(input longint r, input int w, input bit sat, output longint res, output bit o);
    longint lo, hi, m, t;
    lo = -(longint'(1) <<< (w - 1));
    hi = (longint'(1) <<< (w - 1)) - 1;
    m  = longint'(1) <<< w;
    o  = (r > hi) || (r < lo);
    res = r;
    if (o) begin
      if (sat) res = (r > hi) ? hi : lo;
      else begin
        t = (r - lo) % m;
        if (t < 0) t += m;
        res = t + lo;
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      bit rdy;
      rdy = !m_v[k] || out_ready;
      if (rst) begin
        for (int c = 0; c < 4; c++) begin m_acc[k][c] = 0; m_ovf[k][c] = 0; end
        m_v[k] = 0; m_ch[k] = 0; m_out[k] = 0; m_o[k] = 0;
      end else begin
        if (m_v[k] && out_ready) m_v[k] = 0;
        if (in_valid && rdy && int'(in_ch) < cfg_nch(k)) begin
          int c;
          longint r;
          bit o;
          c = int'(in_ch);
          case (in_op)
            2'd1: begin
              fit(m_acc[k][c] + longint'(in_data), cfg_accw(k), cfg_sat(k), r, o);
              m_acc[k][c] = r; m_ovf[k][c] = m_ovf[k][c] | o;
            end
            2'd2: begin
              fit(m_acc[k][c] - longint'(in_data), cfg_accw(k), cfg_sat(k), r, o);
              m_acc[k][c] = r; m_ovf[k][c] = m_ovf[k][c] | o;
            end
            2'd3: begin m_acc[k][c] = 0; m_ovf[k][c] = 0; end
            default: ;
          endcase
          m_v[k] = 1; m_ch[k] = c; m_out[k] = m_acc[k][c]; m_o[k] = m_ovf[k][c];
        end
      end
    end
  endtask

  // One clock: drive, check ready before the edge, advance model, compare after the edge.
  task automatic step(input bit r, input bit v, input logic [1:0] ch, input logic [1:0] op,
                      input int d, input bit ordy);
    bit dv, dovf, drdy;
    int dch;
    longint dacc;
    rst = r; in_valid = v; in_ch = ch; in_op = op; in_data = 16'(d); out_ready = ordy;
    #1;
    for (int k = 0; k < NK; k++) begin
      get_dut(k, dv, dch, dacc, dovf, drdy);
      rdy_seen[k] = drdy;
      if (started) check($sformatf("in_ready[%0d]", k), longint'(drdy), longint'(!m_v[k] || ordy));
    end
    started = 1'b1;
    model_edge();
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      get_dut(k, dv, dch, dacc, dovf, drdy);
      check($sformatf("out_valid[%0d]", k), longint'(dv), longint'(m_v[k]));
      if (m_v[k]) begin
        check($sformatf("out_ch[%0d]", k), longint'(dch), longint'(m_ch[k]));
        check($sformatf("out_acc[%0d]", k), dacc, m_out[k]);
        check($sformatf("out_ovf[%0d]", k), longint'(dovf), longint'(m_o[k]));
      end
    end
  endtask

  task automatic expect_out(input string nm, input int k, input bit ev, input int ech,
                            input longint eacc, input bit eovf);
    bit dv, dovf, drdy;
    int dch;
    longint dacc;
    get_dut(k, dv, dch, dacc, dovf, drdy);
    check({nm, ".valid"}, longint'(dv), longint'(ev));
    check({nm, ".ch"}, longint'(dch), longint'(ech));
    check({nm, ".acc"}, dacc, eacc);
    check({nm, ".ovf"}, longint'(dovf), longint'(eovf));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] ch;
    int         data;
    longint     exp_acc;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl [11];

  localparam logic [1:0] RD = 2'd0, AD = 2'd1, SB = 2'd2, CL = 2'd3;

  initial begin
    longint e1 [3];
    longint e2 [3];
    bit     eo [3];
    bit     dv, dovf, drdy;
    int     dch;
    longint dacc;

    n_tests = 0; n_fail = 0; started = 1'b0;
    for (int k = 0; k < NK; k++) begin
      m_v[k] = 0; m_ch[k] = 0; m_out[k] = 0; m_o[k] = 0;
      for (int c = 0; c < 4; c++) begin m_acc[k][c] = 0; m_ovf[k][c] = 0; end
    end

    tbl[0]  = '{AD, 2'd0, 5,      5,     1'b0};
    tbl[1]  = '{SB, 2'd0, 3,      2,     1'b0};
    tbl[2]  = '{SB, 2'd1, -32768, 32768, 1'b0};
    tbl[3]  = '{RD, 2'd0, 1234,   2,     1'b0};
    tbl[4]  = '{AD, 2'd3, 1,      1,     1'b0};
    tbl[5]  = '{AD, 2'd3, 1,      2,     1'b0};
    tbl[6]  = '{AD, 2'd3, 1,      3,     1'b0};
    tbl[7]  = '{AD, 2'd3, 1,      4,     1'b0};
    tbl[8]  = '{RD, 2'd3, 0,      4,     1'b0};
    tbl[9]  = '{CL, 2'd0, 77,     0,     1'b0};
    tbl[10] = '{RD, 2'd1, 0,      32768, 1'b0};

    // Reset with out_ready low: in_ready must still be 1 because out_valid is 0.
    step(1, 1, 2'd2, AD, 9, 0);
    step(1, 0, 2'd0, RD, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0);
    get_dut(0, dv, dch, dacc, dovf, drdy);
    check("reset.in_ready", longint'(drdy), 1);

    for (int i = 0; i < 11; i++) begin
      step(0, 1, tbl[i].ch, tbl[i].op, tbl[i].data, 1);
      expect_out($sformatf("tbl%0d", i), 0, 1, int'(tbl[i].ch), tbl[i].exp_acc, tbl[i].exp_ovf);
    end

    // Back-pressure: result 7 must stay frozen while the next request waits.
    step(0, 1, 2'd0, AD, 7, 1);
    expect_out("stall.first", 0, 1, 0, 7, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd0, AD, 100, 0);
      check($sformatf("stall.in_ready%0d", i), longint'(rdy_seen[0]), 0);
      expect_out($sformatf("stall.hold%0d", i), 0, 1, 0, 7, 0);
    end
    step(0, 1, 2'd0, AD, 100, 1);
    check("stall.release_ready", longint'(rdy_seen[0]), 1);
    expect_out("stall.release", 0, 1, 0, 107, 0);
    step(0, 1, 2'd0, RD, 0, 1);
    expect_out("stall.read", 0, 1, 0, 107, 0);
    step(0, 0, 2'd0, RD, 0, 1);
    get_dut(0, dv, dch, dacc, dovf, drdy);
    check("drain.valid", longint'(dv), 0);

    // Channel 3 does not exist in the 3-channel config: accepted, no result.
    step(0, 1, 2'd3, AD, 9, 1);
    expect_out("drop.dut0", 0, 1, 3, 13, 0);
    get_dut(2, dv, dch, dacc, dovf, drdy);
    check("drop.dut2_valid", longint'(dv), 0);

    // Reset in the middle of traffic wins over the request.
    step(0, 1, 2'd1, AD, 5, 1);
    expect_out("pre_rst", 0, 1, 1, 32773, 0);
    step(1, 1, 2'd1, AD, 5, 1);
    expect_out("mid_rst", 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 2'(c), RD, 0, 1);
      expect_out($sformatf("rst_read%0d", c), 0, 1, c, 0, 0);
    end

    // Positive overflow on the 17-bit configs.
    e1 = '{32767, 65534, 65535};
    e2 = '{32767, 65534, -32771};
    eo = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd2, AD, 32767, 1);
      expect_out($sformatf("pos_sat%0d", i), 1, 1, 2, e1[i], eo[i]);
      expect_out($sformatf("pos_wrap%0d", i), 2, 1, 2, e2[i], eo[i]);
    end
    expect_out("pos_wide", 0, 1, 2, 98301, 0);
    step(0, 1, 2'd2, RD, 0, 1);
    expect_out("pos_sat_rd", 1, 1, 2, 65535, 1);
    expect_out("pos_wrap_rd", 2, 1, 2, -32771, 1);
    step(0, 1, 2'd2, AD, 1, 1);
    expect_out("sticky_sat", 1, 1, 2, 65535, 1);
    expect_out("sticky_wrap", 2, 1, 2, -32770, 1);
    step(0, 1, 2'd2, CL, 5, 1);
    expect_out("clr_sat", 1, 1, 2, 0, 0);
    expect_out("clr_wrap", 2, 1, 2, 0, 0);

    // Negative overflow.
    e1 = '{-32767, -65534, -65536};
    e2 = '{-32767, -65534, 32771};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd2, SB, 32767, 1);
      expect_out($sformatf("neg_sat%0d", i), 1, 1, 2, e1[i], eo[i]);
      expect_out($sformatf("neg_wrap%0d", i), 2, 1, 2, e2[i], eo[i]);
    end

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int r, d, sel;
      logic [1:0] op;
      r = $urandom_range(0, 15);
      op = (r < 1) ? CL : (r < 4) ? RD : (r < 10) ? AD : SB;
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? -32768 : (sel == 1) ? 32767 : (int'($urandom_range(0, 65535)) - 32768);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), op, d, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
